game_sequencer: RTL and testbench

Frame-synchronous game controller for the shooting game. Sequences the round lifecycle (menu, countdown, running, win screens) and turns the VGA frame rate into a one-cycle `game_tick` enable. Delivers per-tick frozen player controls with one-shot shoot requests to the color/game datapath. Sits between the button inputs and VGA sync generator on one side and the color generator datapath on the other; it replaces free-running `game_clk` sequencing with a tick enable in the `vga_clk` domain.

---
 rtl/game_sequencer_if.sv | 35 +++
 rtl/game_sequencer.sv | 175 +++++++++++++++++
 tb/tb_game_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Button, VGA sync and datapath bundle for game_sequencer.
// The pause button exists only when GAME_PAUSE_EN is defined.
interface game_sequencer_if;
  logic       vsync_start;
  logic       start;
  logic [4:0] p1_control_raw;
  logic [4:0] p2_control_raw;
  logic [1:0] p1_health;
  logic [1:0] p2_health;
`ifdef GAME_PAUSE_EN
  logic       pause;
`endif
  logic       game_tick;
  logic [4:0] p1_control;
  logic [4:0] p2_control;
  logic [2:0] game_state;
  logic       round_reset;
  logic [1:0] countdown;

  modport master (
`ifdef GAME_PAUSE_EN
    output pause,
`endif
    output vsync_start, start, p1_control_raw, p2_control_raw, p1_health, p2_health,
    input  game_tick, p1_control, p2_control, game_state, round_reset, countdown
  );

  modport slave (
`ifdef GAME_PAUSE_EN
    input  pause,
`endif
    input  vsync_start, start, p1_control_raw, p2_control_raw, p1_health, p2_health,
    output game_tick, p1_control, p2_control, game_state, round_reset, countdown
  );
endinterface

// File: rtl/game_sequencer.sv
// Round lifecycle FSM and frame-divided game_tick generator in the vga_clk domain.
// Optional pause state is compiled in with `define GAME_PAUSE_EN.
module game_sequencer #(
  parameter int TICK_DIV        = 2,
  parameter int COUNT_FRAMES    = 60,
  parameter int WIN_HOLD_FRAMES = 180
) (
  input logic             vga_clk,
  input logic             reset,
  game_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_MENU   = 3'd0,
    S_COUNT  = 3'd1,
    S_RUN    = 3'd2,
    S_WIN_P1 = 3'd3,
    S_WIN_P2 = 3'd4,
    S_PAUSE  = 3'd5
  } state_t;

  localparam logic [7:0] TICK_LAST  = 8'(TICK_DIV - 1);
  localparam logic [7:0] COUNT_LAST = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] WIN_LAST   = 8'(WIN_HOLD_FRAMES - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_frame;
  logic [1:0]  r_countdown;
  logic        r_tick, r_round_reset;
  logic [4:0]  r_p1_ctrl, r_p2_ctrl;
  logic        r_p1_pend, r_p2_pend;
  logic [10:0] r_btn_s1, r_btn_s2;
  logic [2:0]  r_btn_prev;
  logic [2:0]  w_btn_now, w_btn_edge;
  logic        w_start_edge, w_p1_shoot_edge, w_p2_shoot_edge;
  logic        w_p1_dead, w_p2_dead;
  logic        w_cnt_wrap, w_tick_nxt;
  logic        w_state_chg, w_enter_count, w_leave_run, w_cnt_hold;

  // Synchronizer layout: {start, p1 {shoot,r,l,d,u}, p2 {shoot,r,l,d,u}}
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_btn_prev <= '0;
    end else begin
      r_btn_s1   <= {bus.start, bus.p1_control_raw, bus.p2_control_raw};
      r_btn_s2   <= r_btn_s1;
      r_btn_prev <= w_btn_now;
    end
  end

  assign w_btn_now  = {r_btn_s2[10], r_btn_s2[9], r_btn_s2[4]};
  assign w_btn_edge = w_btn_now & ~r_btn_prev;
  assign {w_start_edge, w_p1_shoot_edge, w_p2_shoot_edge} = w_btn_edge;
  assign w_p1_dead  = (bus.p1_health == 2'd0);
  assign w_p2_dead  = (bus.p2_health == 2'd0);

`ifdef GAME_PAUSE_EN
  logic r_pause_s1, r_pause_s2, r_pause_prev, w_pause_edge;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_pause_s1   <= 1'b0;
      r_pause_s2   <= 1'b0;
      r_pause_prev <= 1'b0;
    end else begin
      r_pause_s1   <= bus.pause;
      r_pause_s2   <= r_pause_s1;
      r_pause_prev <= r_pause_s2;
    end
  end

  assign w_pause_edge = r_pause_s2 & ~r_pause_prev;
`endif

  always_ff @(posedge vga_clk) begin
    if (reset) r_state <= S_MENU;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_wrap  = 1'b0;
    w_tick_nxt  = 1'b0;
    case (r_state)
      S_MENU: if (w_start_edge) w_state_nxt = S_COUNT;
      S_COUNT: begin
        if (bus.vsync_start && r_frame == COUNT_LAST) begin
          w_cnt_wrap = 1'b1;
          if (r_countdown == 2'd1) w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // Round end beats pause and tick so no tick escapes into a win/menu screen
        if (w_p1_dead && w_p2_dead)      w_state_nxt = S_MENU;
        else if (w_p1_dead)              w_state_nxt = S_WIN_P2;
        else if (w_p2_dead)              w_state_nxt = S_WIN_P1;
`ifdef GAME_PAUSE_EN
        else if (w_pause_edge)           w_state_nxt = S_PAUSE;
`endif
        else if (bus.vsync_start && r_frame == TICK_LAST) begin
          w_cnt_wrap = 1'b1;
          w_tick_nxt = 1'b1;
        end
      end
      S_WIN_P1, S_WIN_P2: begin
        if (w_start_edge)                                     w_state_nxt = S_COUNT;
        else if (bus.vsync_start && r_frame == WIN_LAST)      w_state_nxt = S_MENU;
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: if (w_pause_edge) w_state_nxt = S_RUN;
`endif
      default: w_state_nxt = S_MENU;
    endcase
  end

  always_comb begin
    w_state_chg    = (w_state_nxt != r_state);
    w_enter_count  = w_state_chg && (w_state_nxt == S_COUNT);
    w_leave_run    = (r_state == S_RUN) && (w_state_nxt != S_RUN) && (w_state_nxt != S_PAUSE);
    w_cnt_hold     = 1'b0;
`ifdef GAME_PAUSE_EN
    // The frame count survives RUN<->PAUSE so the tick cadence resumes where it stopped
    w_cnt_hold     = (r_state == S_PAUSE) || (w_state_nxt == S_PAUSE);
`endif
    bus.game_state  = r_state;
    bus.game_tick   = r_tick;
    bus.round_reset = r_round_reset;
    bus.countdown   = r_countdown;
    bus.p1_control  = r_p1_ctrl;
    bus.p2_control  = r_p2_ctrl;
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_frame <= '0;
    end else if (!w_cnt_hold) begin
      if (w_state_chg || w_cnt_wrap) r_frame <= '0;
      else if (bus.vsync_start)      r_frame <= r_frame + 8'd1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_countdown   <= '0;
      r_tick        <= 1'b0;
      r_round_reset <= 1'b0;
    end else begin
      r_tick        <= w_tick_nxt;
      r_round_reset <= w_enter_count;
      if (w_enter_count)                         r_countdown <= 2'd3;
      else if (w_cnt_wrap && r_state == S_COUNT) r_countdown <= r_countdown - 2'd1;
    end
  end

  // A shoot edge on the load cycle is folded straight into the loaded value
  always_ff @(posedge vga_clk) begin
    if (reset || w_leave_run) begin
      r_p1_ctrl <= '0;
      r_p2_ctrl <= '0;
      r_p1_pend <= 1'b0;
      r_p2_pend <= 1'b0;
    end else if (r_state == S_RUN && w_state_nxt == S_RUN) begin
      if (w_tick_nxt) begin
        r_p1_ctrl <= {r_p1_pend | w_p1_shoot_edge, r_btn_s2[8:5]};
        r_p2_ctrl <= {r_p2_pend | w_p2_shoot_edge, r_btn_s2[3:0]};
        r_p1_pend <= 1'b0;
        r_p2_pend <= 1'b0;
      end else begin
        r_p1_pend <= r_p1_pend | w_p1_shoot_edge;
        r_p2_pend <= r_p2_pend | w_p2_shoot_edge;
      end
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// Scenario bench for game_sequencer: round lifecycle, tick cadence, shoot latching, win/reset paths.
module tb_game_sequencer;
  localparam int TICK_DIV  = 2;
  localparam int CNT_FR    = 2;
  localparam int WIN_HOLD  = 180;
  localparam int IDLE      = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  game_sequencer_if bus();

  game_sequencer #(.TICK_DIV(TICK_DIV), .COUNT_FRAMES(CNT_FR), .WIN_HOLD_FRAMES(WIN_HOLD)) dut (
    .vga_clk(clk),
    .reset  (reset),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  int rr_cnt = 0;
  int stray_tick = 0;
  int dbl_tick = 0;
  logic prev_tick = 1'b0;

  always @(negedge clk) begin
    if (bus.game_tick) tick_cnt++;
    if (bus.round_reset) rr_cnt++;
    if (bus.game_tick && bus.game_state != 3'd2) stray_tick++;
    if (bus.game_tick && prev_tick) dbl_tick++;
    prev_tick = bus.game_tick;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic vs();
    bus.vsync_start = 1'b1; cyc(); bus.vsync_start = 1'b0;
  endtask

  task automatic frame();
    repeat (IDLE) cyc();
    vs();
  endtask

  task automatic short_frame();
    repeat (2) cyc();
    vs();
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (bus.game_state !== s && n < budget) begin cyc(); n++; end
  endtask

  task automatic press_start();
    bus.start = 1'b1; repeat (4) cyc(); bus.start = 1'b0;
  endtask

  task automatic to_run();
    press_start();
    wait_state(3'd1, 10);
    repeat (3 * CNT_FR) frame();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    checks++; if (bus.game_state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", bus.game_state); end
    checks++; if (bus.game_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %0b want 0", bus.game_tick); end
    checks++; if (bus.round_reset !== 1'b0) begin failures++; $display("FAIL reset_rr: got %0b want 0", bus.round_reset); end
    checks++; if (bus.countdown !== 2'd0) begin failures++; $display("FAIL reset_countdown: got %0d want 0", bus.countdown); end
    checks++; if ({bus.p1_control, bus.p2_control} !== 10'd0) begin failures++; $display("FAIL reset_controls: got %h/%h want 0/0", bus.p1_control, bus.p2_control); end
  endtask

  task automatic test_countdown();
    int rr0 = rr_cnt;
    press_start();
    wait_state(3'd1, 10);
    checks++; if (bus.game_state !== 3'd1) begin failures++; $display("FAIL count_entry: got %0d want 1", bus.game_state); end
    checks++; if (bus.countdown !== 2'd3) begin failures++; $display("FAIL count_initial: got %0d want 3", bus.countdown); end
    repeat (3) cyc();
    checks++; if (rr_cnt - rr0 !== 1) begin failures++; $display("FAIL round_reset_once: got %0d pulses want 1", rr_cnt - rr0); end
    for (int i = 1; i <= 3 * CNT_FR; i++) begin
      logic [2:0] es;
      logic [1:0] ec;
      frame();
      es = (i == 3 * CNT_FR) ? 3'd2 : 3'd1;
      ec = 2'(3 - i / CNT_FR);
      checks++; if (bus.game_state !== es) begin failures++; $display("FAIL count_state[%0d]: got %0d want %0d", i, bus.game_state, es); end
      checks++; if (bus.countdown !== ec) begin failures++; $display("FAIL count_value[%0d]: got %0d want %0d", i, bus.countdown, ec); end
    end
  endtask

  task automatic test_ticks();
    int t0 = tick_cnt;
    int d0 = dbl_tick;
    for (int i = 1; i <= 10; i++) begin
      logic et;
      frame();
      et = (i % TICK_DIV == 0);
      checks++; if (bus.game_tick !== et) begin failures++; $display("FAIL tick_after_vsync[%0d]: got %0b want %0b", i, bus.game_tick, et); end
      cyc();
      checks++; if (bus.game_tick !== 1'b0) begin failures++; $display("FAIL tick_width[%0d]: got %0b want 0", i, bus.game_tick); end
    end
    cyc();
    checks++; if (tick_cnt - t0 !== 10 / TICK_DIV) begin failures++; $display("FAIL tick_count: got %0d want %0d", tick_cnt - t0, 10 / TICK_DIV); end
    checks++; if (dbl_tick !== d0) begin failures++; $display("FAIL tick_double: got %0d wide ticks want 0", dbl_tick - d0); end
  endtask

  task automatic test_shoot();
    logic [4:0] raw1 = 5'd0, raw2 = 5'd0, n1, n2, exp1 = 5'd0, exp2 = 5'd0;
    logic pend1 = 1'b0, pend2 = 1'b0;
    logic [7:0] p1_shoot_tbl = 8'b1111_1101;
    for (int f = 0; f < 24; f++) begin
      repeat (2) cyc();
      n1 = 5'($urandom);
      n2 = 5'($urandom);
      if (f < 8) n1[4] = p1_shoot_tbl[f];
      if (!raw1[4] && n1[4]) pend1 = 1'b1;
      if (!raw2[4] && n2[4]) pend2 = 1'b1;
      raw1 = n1; raw2 = n2;
      bus.p1_control_raw = raw1;
      bus.p2_control_raw = raw2;
      repeat (IDLE - 2) cyc();
      vs();
      if ((f + 1) % TICK_DIV == 0) begin
        exp1 = {pend1, raw1[3:0]}; pend1 = 1'b0;
        exp2 = {pend2, raw2[3:0]}; pend2 = 1'b0;
      end
      checks++; if (bus.p1_control !== exp1) begin failures++; $display("FAIL p1_control[%0d]: got %b want %b", f, bus.p1_control, exp1); end
      checks++; if (bus.p2_control !== exp2) begin failures++; $display("FAIL p2_control[%0d]: got %b want %b", f, bus.p2_control, exp2); end
    end
    bus.p1_control_raw = 5'd0;
    bus.p2_control_raw = 5'd0;
    repeat (4) cyc();
  endtask

  task automatic test_win_p1();
    int t0;
    bus.p2_health = 2'd0;
    cyc();
    checks++; if (bus.game_state !== 3'd3) begin failures++; $display("FAIL win_p1_entry: got %0d want 3", bus.game_state); end
    checks++; if ({bus.p1_control, bus.p2_control} !== 10'd0) begin failures++; $display("FAIL win_controls_cleared: got %h/%h want 0/0", bus.p1_control, bus.p2_control); end
    bus.p2_health = 2'd3;
    t0 = tick_cnt;
    for (int i = 1; i <= WIN_HOLD; i++) begin
      short_frame();
      if (i == WIN_HOLD - 1) begin
        checks++; if (bus.game_state !== 3'd3) begin failures++; $display("FAIL win_hold: got %0d want 3", bus.game_state); end
      end
    end
    checks++; if (bus.game_state !== 3'd0) begin failures++; $display("FAIL win_timeout: got %0d want 0", bus.game_state); end
    cyc();
    checks++; if (tick_cnt !== t0) begin failures++; $display("FAIL win_no_tick: got %0d ticks want 0", tick_cnt - t0); end
  endtask

  task automatic test_rematch();
    int rr0;
    to_run();
    checks++; if (bus.game_state !== 3'd2) begin failures++; $display("FAIL rematch_run: got %0d want 2", bus.game_state); end
    bus.p1_health = 2'd0;
    cyc();
    checks++; if (bus.game_state !== 3'd4) begin failures++; $display("FAIL win_p2_entry: got %0d want 4", bus.game_state); end
    bus.p1_health = 2'd3;
    repeat (50) short_frame();
    rr0 = rr_cnt;
    press_start();
    wait_state(3'd1, 10);
    checks++; if (bus.game_state !== 3'd1) begin failures++; $display("FAIL rematch_count: got %0d want 1", bus.game_state); end
    checks++; if (bus.countdown !== 2'd3) begin failures++; $display("FAIL rematch_countdown: got %0d want 3", bus.countdown); end
    repeat (2) cyc();
    checks++; if (rr_cnt - rr0 !== 1) begin failures++; $display("FAIL rematch_round_reset: got %0d want 1", rr_cnt - rr0); end
    repeat (3 * CNT_FR) frame();
  endtask

  task automatic test_both_zero();
    int t0;
    checks++; if (bus.game_state !== 3'd2) begin failures++; $display("FAIL both_zero_pre: got %0d want 2", bus.game_state); end
    frame();
    bus.p1_health = 2'd0;
    bus.p2_health = 2'd0;
    cyc();
    checks++; if (bus.game_state !== 3'd0) begin failures++; $display("FAIL both_zero_menu: got %0d want 0", bus.game_state); end
    bus.p1_health = 2'd3;
    bus.p2_health = 2'd3;
    t0 = tick_cnt;
    repeat (6) frame();
    cyc();
    checks++; if (tick_cnt !== t0) begin failures++; $display("FAIL both_zero_no_tick: got %0d ticks want 0", tick_cnt - t0); end
    checks++; if (bus.game_state !== 3'd0) begin failures++; $display("FAIL both_zero_stay: got %0d want 0", bus.game_state); end
  endtask

  task automatic test_reset_mid_run();
    to_run();
    bus.p1_control_raw = 5'b01010;
    bus.p2_control_raw = 5'b00101;
    repeat (TICK_DIV) frame();
    checks++; if (bus.p1_control !== 5'b01010) begin failures++; $display("FAIL pre_reset_load: got %b want 01010", bus.p1_control); end
    frame();
    repeat (IDLE) cyc();
    reset = 1'b1;
    bus.vsync_start = 1'b1;
    cyc();
    bus.vsync_start = 1'b0;
    checks++; if (bus.game_state !== 3'd0) begin failures++; $display("FAIL midrst_state: got %0d want 0", bus.game_state); end
    checks++; if ({bus.game_tick, bus.round_reset, bus.countdown} !== 4'd0) begin failures++; $display("FAIL midrst_strobes: got tick=%0b rr=%0b cd=%0d want 0", bus.game_tick, bus.round_reset, bus.countdown); end
    checks++; if ({bus.p1_control, bus.p2_control} !== 10'd0) begin failures++; $display("FAIL midrst_controls: got %h/%h want 0/0", bus.p1_control, bus.p2_control); end
    cyc();
    checks++; if (bus.game_tick !== 1'b0) begin failures++; $display("FAIL midrst_late_tick: got %0b want 0", bus.game_tick); end
    reset = 1'b0;
    bus.p1_control_raw = 5'd0;
    bus.p2_control_raw = 5'd0;
    repeat (4) cyc();
  endtask

`ifdef GAME_PAUSE_EN
  task automatic test_pause();
    int t0;
    logic [4:0] held;
    to_run();
    bus.p1_control_raw = 5'b00110;
    repeat (TICK_DIV) frame();
    held = bus.p1_control;
    frame();
    bus.pause = 1'b1; repeat (4) cyc(); bus.pause = 1'b0;
    wait_state(3'd5, 10);
    checks++; if (bus.game_state !== 3'd5) begin failures++; $display("FAIL pause_entry: got %0d want 5", bus.game_state); end
    bus.p1_control_raw = 5'b11001;
    t0 = tick_cnt;
    repeat (20) frame();
    cyc();
    checks++; if (tick_cnt !== t0) begin failures++; $display("FAIL pause_no_tick: got %0d ticks want 0", tick_cnt - t0); end
    checks++; if (bus.p1_control !== held) begin failures++; $display("FAIL pause_hold: got %b want %b", bus.p1_control, held); end
    bus.pause = 1'b1; repeat (4) cyc(); bus.pause = 1'b0;
    wait_state(3'd2, 10);
    checks++; if (bus.game_state !== 3'd2) begin failures++; $display("FAIL unpause: got %0d want 2", bus.game_state); end
    repeat (TICK_DIV - 1) frame();
    checks++; if (bus.game_tick !== 1'b1) begin failures++; $display("FAIL resume_cadence: got %0b want 1", bus.game_tick); end
    bus.p1_control_raw = 5'd0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.vsync_start = 1'b0;
    bus.start = 1'b0;
    bus.p1_control_raw = 5'd0;
    bus.p2_control_raw = 5'd0;
    bus.p1_health = 2'd3;
    bus.p2_health = 2'd3;
`ifdef GAME_PAUSE_EN
    bus.pause = 1'b0;
`endif
    test_reset();
    test_countdown();
    test_ticks();
    test_shoot();
    test_win_p1();
    test_rematch();
    test_both_zero();
    test_reset_mid_run();
`ifdef GAME_PAUSE_EN
    test_pause();
`endif
    checks++; if (stray_tick !== 0) begin failures++; $display("FAIL tick_outside_run: got %0d want 0", stray_tick); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
